// File: rtl/linebuffer_pkg.sv
// Shared definitions for the multi-bank sprite line buffer: data width helper,
// default backdrop value and the readout FSM state type.
package linebuffer_pkg;

  localparam int DEF_PW = 8;
  localparam int DEF_CW = 4;

  function automatic int calc_dw(input int pw, input int cw);
    return pw + cw;
  endfunction

  localparam int DEF_DW = calc_dw(DEF_PW, DEF_CW);
  localparam logic [DEF_DW-1:0] DEF_CLEAR_VAL = '1;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

endpackage

// File: rtl/linebuffer_bank_if.sv
// Pixel-write / line-readout bus of the sprite line buffer.
// master = sprite renderer + video side, slave = linebuffer_bank.
interface linebuffer_bank_if
  import linebuffer_pkg::*;
#(
  parameter int AW = 8,
  parameter int CW = 4,
  parameter int PW = 8
);
  localparam int DW = calc_dw(PW, CW);

  logic          FLIP;
  logic          WR_LOAD;
  logic [AW-1:0] WR_X;
  logic [PW-1:0] WR_PAL;
  logic          WR_VALID;
  logic [CW-1:0] WR_COLOR;
  logic          RD_START;
  logic [DW-1:0] RD_DATA;
  logic          RD_VALID;
  logic          OVERRUN;

  modport master (
    output FLIP, WR_LOAD, WR_X, WR_PAL, WR_VALID, WR_COLOR, RD_START,
    input  RD_DATA, RD_VALID, OVERRUN
  );

  modport slave (
    input  FLIP, WR_LOAD, WR_X, WR_PAL, WR_VALID, WR_COLOR, RD_START,
    output RD_DATA, RD_VALID, OVERRUN
  );
endinterface

// File: rtl/lb_bank.sv
// One line-buffer bank: sync write port plus read-first registered read port,
// so a clear written at the read address never corrupts the pixel being read.
module lb_bank #(
  parameter int SIZE = 256,
  parameter int AW = 8,
  parameter int DW = 12,
  parameter logic [DW-1:0] RST_VAL = '1
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [SIZE];
  logic [DW-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (srst) q_reg <= RST_VAL;
    else if (re) q_reg <= mem[raddr];
  end

  assign q = q_reg;
endmodule

// File: rtl/linebuffer_bank.sv
// Multi-bank sprite line buffer with bank rotation, transparency skip and
// clear-after-read. Optional macro LINEBUFFER_OVERRUN_CHECK_EN enables range checking.
module linebuffer_bank
  import linebuffer_pkg::*;
#(
  parameter int DEPTH = 192,
  parameter int AW = 8,
  parameter int CW = 4,
  parameter int PW = 8,
  parameter int NBUF = 2,
  parameter logic [PW+CW-1:0] CLEAR_VAL = '1
) (
  input logic          CK,
  input logic          RESET,
  linebuffer_bank_if.slave bus
);
  localparam int DW = calc_dw(PW, CW);
  localparam int BW = (NBUF > 1) ? $clog2(NBUF) : 1;
`ifdef LINEBUFFER_OVERRUN_CHECK_EN
  localparam int SIZE = DEPTH;
`else
  localparam int SIZE = 1 << AW;
`endif

  logic [BW-1:0] wb_reg, wb_next, rb, rd_bank_reg;
  logic [AW-1:0] wx_reg, wx_next, wr_addr, rx_reg, rx_next;
  logic [PW-1:0] pal_reg, pal_next, wr_pal;
  rd_state_t     state_reg, state_next;
  logic          rd_fire, pix_we, rd_valid_reg;
  logic [DW-1:0] bank_q [NBUF];

  // Read bank trails the write bank by one, modulo NBUF.
  assign rb = (wb_reg == '0) ? BW'(NBUF - 1) : wb_reg - BW'(1);
  assign wb_next = !bus.FLIP ? wb_reg :
                   (wb_reg == BW'(NBUF - 1)) ? '0 : wb_reg + BW'(1);

  always_comb begin
    wr_addr  = bus.WR_LOAD ? bus.WR_X : wx_reg;
    wr_pal   = bus.WR_LOAD ? bus.WR_PAL : pal_reg;
    pal_next = wr_pal;
    wx_next  = wr_addr;
    if (bus.WR_VALID) wx_next = wr_addr + AW'(1);
    pix_we   = bus.WR_VALID && (bus.WR_COLOR != '0);
  end

`ifdef LINEBUFFER_OVERRUN_CHECK_EN
  logic overrun_reg, pix_oor, pix_wr;
  assign pix_oor = pix_we && (32'(wr_addr) >= DEPTH);
  assign pix_wr  = pix_we && !pix_oor;

  always_ff @(posedge CK) begin
    if (RESET) overrun_reg <= 1'b0;
    else if (pix_oor) overrun_reg <= 1'b1;
  end
  assign bus.OVERRUN = overrun_reg;
`else
  logic pix_wr;
  assign pix_wr = pix_we;
  assign bus.OVERRUN = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    rx_next    = rx_reg;
    rd_fire    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.RD_START && !bus.FLIP) begin
          state_next = READ;
          rx_next    = '0;
        end
      end
      READ: begin
        if (bus.FLIP) begin
          state_next = IDLE;
        end else begin
          // A restart still consumes the current pixel, then rewinds.
          rd_fire = 1'b1;
          rx_next = rx_reg + AW'(1);
          if (bus.RD_START) rx_next = '0;
          else if (rx_reg == AW'(DEPTH - 1)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RESET) begin
      wb_reg       <= '0;
      wx_reg       <= '0;
      rx_reg       <= '0;
      pal_reg      <= '0;
      state_reg    <= IDLE;
      rd_valid_reg <= 1'b0;
      rd_bank_reg  <= '0;
    end else begin
      wb_reg       <= wb_next;
      wx_reg       <= wx_next;
      rx_reg       <= rx_next;
      pal_reg      <= pal_next;
      state_reg    <= state_next;
      rd_valid_reg <= rd_fire;
      if (rd_fire) rd_bank_reg <= rb;
    end
  end

  generate
    for (genvar gi = 0; gi < NBUF; gi++) begin : g_bank
      logic          bwe, bre;
      logic [AW-1:0] baddr;
      logic [DW-1:0] bdata;

      // Write bank takes renderer pixels; read bank takes the clear stream.
      always_comb begin
        bwe   = 1'b0;
        baddr = rx_reg;
        bdata = CLEAR_VAL;
        bre   = 1'b0;
        if (wb_reg == BW'(gi)) begin
          bwe   = pix_wr;
          baddr = wr_addr;
          bdata = {wr_pal, bus.WR_COLOR};
        end else if (rb == BW'(gi)) begin
          bwe = rd_fire;
          bre = rd_fire;
        end
      end

      lb_bank #(
        .SIZE   (SIZE),
        .AW     (AW),
        .DW     (DW),
        .RST_VAL(CLEAR_VAL)
      ) u_bank (
        .clk  (CK),
        .srst (RESET),
        .we   (bwe),
        .waddr(baddr),
        .wdata(bdata),
        .re   (bre),
        .raddr(rx_reg),
        .q    (bank_q[gi])
      );
    end
  endgenerate

  assign bus.RD_DATA  = bank_q[rd_bank_reg];
  assign bus.RD_VALID = rd_valid_reg;
endmodule

// File: doc/linebuffer_bank.md
# linebuffer_bank

Parametrised multi-bank sprite line buffer, successor to the single-bank Neo Geo line buffer. The sprite renderer writes palette+color-index pixels into the current write bank while the video output side reads a previously completed bank sequentially and clears it to the backdrop value as it goes. The block sits between the sprite pixel pipeline and the palette RAM address mux. It adds bank rotation, transparency skipping and clear-after-read in a single clock domain.

## Interface
- DEPTH, 192: pixels per line; valid X range 0..DEPTH-1.
- AW, 8: address/X counter width; must satisfy 2^AW >= DEPTH.
- CW, 4: color index width.
- PW, 8: sprite palette width; data width DW = PW+CW.
- NBUF, 2: number of banks (2..4).
- CLEAR_VAL, all ones (DW bits): backdrop value written on clear.

Ports:
- CK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- FLIP  in  1  one-cycle pulse at line end; rotates banks.
- WR_LOAD  in  1  load write X counter and palette.
- WR_X  in  AW  start X for WR_LOAD.
- WR_PAL  in  PW  sprite palette latched on WR_LOAD.
- WR_VALID  in  1  one pixel presented this cycle.
- WR_COLOR  in  CW  pixel color index; 0 = transparent.
- RD_START  in  1  start sequential readout of the read bank.
- RD_DATA  out  DW  {palette, color} of current read pixel.
- RD_VALID  out  1  RD_DATA valid.
- OVERRUN  out  1  sticky out-of-range write flag (see Configuration).

## Operation
- Write bank index WB (0..NBUF-1); read bank RB = (WB-1) mod NBUF. FLIP: WB <= (WB+1) mod NBUF.
- WR_LOAD: write counter WX <= WR_X, palette reg <= WR_PAL.
- WR_VALID: if WR_COLOR != 0, bank[WB][WX] <= {pal, WR_COLOR}; WX <= WX+1 regardless of transparency.
- WR_LOAD and WR_VALID same cycle: pixel written at WR_X with WR_PAL; WX <= WR_X+1.
- Read FSM: IDLE, READ. IDLE + RD_START -> READ, RX <= 0. READ: each cycle read bank[RB][RX], write bank[RB][RX] <= CLEAR_VAL, RX <= RX+1; RX = DEPTH-1 -> IDLE after that pixel.
- RD_START in READ restarts at RX = 0 (already-cleared pixels read as CLEAR_VAL).
- FLIP in READ aborts read -> IDLE; remaining pixels of that bank are not cleared.
- FLIP same cycle as WR_VALID: pixel goes to old WB. FLIP same cycle as RD_START: start ignored.
- Write and read banks are always distinct (NBUF >= 2); no port conflict.
- RAM contents not reset; each bank holds undefined data until it has been read once.
- Reset: WB = 0, WX = 0, RX = 0, palette reg = 0, FSM IDLE, RD_VALID = 0, RD_DATA = CLEAR_VAL, OVERRUN = 0.

## Timing
- Write: visible in bank at next edge; readable only after enough FLIPs to make that bank RB.
- Read latency 1: RD_START at edge t -> RD_VALID high t+1..t+DEPTH, pixel k at t+1+k; RD_VALID low at t+DEPTH+1 unless restarted.
- Clear of address k happens at the same edge that registers pixel k (read-before-write).
- FLIP abort: RD_VALID low from the cycle after FLIP.
- RD_DATA holds last value when RD_VALID = 0.

## Configuration
- LINEBUFFER_OVERRUN_CHECK_EN defined: a write with WX >= DEPTH is suppressed and sets OVERRUN (sticky until RESET); WX still increments and wraps mod 2^AW.
- Undefined: no comparison; WX wraps mod 2^AW and writes go to RAM index WX (storage sized 2^AW); OVERRUN tied 0.

## Structure
- Package linebuffer_pkg: DW computation, default CLEAR_VAL, read FSM state enum (IDLE, READ).
- Sub-module lb_bank: one DEPTH-entry (2^AW when check disabled) x DW RAM, one sync write port, one registered read port; instantiated NBUF times, muxed by WB/RB.

## Test plan
- Reset, FLIP, RD_START: RD_VALID high 192 cycles; after a second full read of same bank all RD_DATA = 0xFFF.
- WR_LOAD X=10 PAL=0x35, colors 1,0,7; FLIP; read: pixel 10 = 0x351, 11 = previous content (0xFFF after clear), 12 = 0x357.
- NBUF=3: write lines A,B,C with FLIP between; reads return A then B, bank rotation wraps 2->0.
- RD_START in READ at RX=50: pixel 0 restarts, pixels 0..49 read 0xFFF; FLIP mid-read: RD_VALID drops next cycle.
- Check enabled: WR_LOAD X=190, 4 opaque pixels -> X 190,191 written, OVERRUN = 1, X 192,193 untouched; RESET clears OVERRUN.
- WR_LOAD + WR_VALID + FLIP same cycle: pixel lands in old write bank at WR_X.
